// File: rtl/apb_slave_bridge.sv
// apb_slave_bridge: APB4 slave that turns each transfer into one wr_en/rd_en strobe on the register bus
// and returns a registered completion, with an ack timeout and protocol-violation detection.
module apb_slave_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wr_en,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rack,
    input  logic                wack,
    input  logic                raddrerr,
    input  logic                waddrerr,
    output logic                proto_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic                write_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic                ack;
    logic                ack_err;
    logic                expire;
    logic [DATA_W-1:0]   prdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                wr_en_q;
    logic                rd_en_q;
    logic                proto_err_q;

    // Only the ack matching the latched direction counts; REQ counts as cycle 1 of the timeout.
    always_comb begin
        ack     = write_q ? wack : rack;
        ack_err = write_q ? waddrerr : raddrerr;
        cnt_d   = (state_q == S_REQ) ? 8'd1 : cnt_q + 8'd1;
        expire  = cnt_d >= 8'(TIMEOUT_CYC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            proto_err_q <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (psel && !penable) begin
                        state_q <= S_REQ;
                        write_q <= pwrite;
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        wstrb_q <= pwrite ? pstrb : '0;
                        wr_en_q <= pwrite;
                        rd_en_q <= !pwrite;
                    end else if (psel && penable) begin
                        proto_err_q <= 1'b1;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (!psel) begin
                        state_q     <= S_IDLE;
                        proto_err_q <= 1'b1;
                    end else if (ack || expire) begin
                        state_q   <= S_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= ack ? ack_err : 1'b1;
                        prdata_q  <= (ack && !write_q && !raddrerr) ? rdata : '0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// tb_apb_slave_bridge: APB master and register-bus responder driving apb_slave_bridge,
// each transfer checked against latency/error/data rules computed in the bench.
module tb_apb_slave_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, rdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata, addr, wdata;
    logic        pready, pslverr, wr_en, rd_en, proto_err;
    logic [3:0]  wstrb;
    logic        rack = 1'b0, wack = 1'b0, raddrerr = 1'b0, waddrerr = 1'b0;

    int total = 0;
    int bad = 0;

    int          o_nstb, o_stb_n, o_rdy_n, o_nrdy, o_nperr, o_perr_n;
    logic        o_wr, o_both, o_err, o_rdy_after;
    logic [31:0] o_addr, o_wdata, o_prdata, o_after;
    logic [3:0]  o_wstrb;

    apb_slave_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .addr(addr), .wdata(wdata), .wstrb(wstrb), .wr_en(wr_en),
        .rd_en(rd_en), .rdata(rdata), .rack(rack), .wack(wack), .raddrerr(raddrerr),
        .waddrerr(waddrerr), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: an ack d cycles after the strobe (0 = same cycle) completes at strobe+d+1
    // if it arrives no later than TIMEOUT_CYC-1; otherwise the timeout completes at strobe+TIMEOUT_CYC.
    function automatic int exp_rdy(input int d);
        return (d >= 0 && d < TO) ? d + 1 : TO;
    endfunction
    function automatic logic exp_err(input int d, input logic aerr);
        return (d >= 0 && d < TO) ? aerr : 1'b1;
    endfunction
    function automatic logic [31:0] exp_data(input logic w, input int d, input logic aerr, input logic [31:0] rd);
        return (d >= 0 && d < TO && !w && !aerr) ? rd : 32'h0;
    endfunction

    // Starts at a negedge with a setup phase; returns at the negedge one cycle after pready.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input int d, input logic aerr, input logic [31:0] rd, input logic stray, input int ab);
        o_nstb = 0; o_stb_n = -1; o_rdy_n = -1; o_nrdy = 0; o_nperr = 0; o_perr_n = -1;
        o_wr = 0; o_both = 0; o_err = 0; o_rdy_after = 0;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_prdata = '1; o_after = '1;
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd; pstrb = st; rack = 0; wack = 0;
        for (int n = 0; n < TO + 5; n++) begin
            @(negedge clk);
            if (wr_en || rd_en) begin
                o_nstb++; o_stb_n = n; o_wr = wr_en; o_addr = addr; o_wdata = wdata; o_wstrb = wstrb;
            end
            if (wr_en && rd_en) o_both = 1;
            if (proto_err) begin o_nperr++; o_perr_n = n; end
            if (o_rdy_n >= 0 && n == o_rdy_n + 1) begin
                o_after = prdata; o_rdy_after = pready;
                break;
            end
            if (pready) begin
                o_nrdy++;
                if (o_rdy_n < 0) begin o_rdy_n = n; o_err = pslverr; o_prdata = prdata; end
            end
            if (ab >= 0 && n >= ab) begin psel = 0; penable = 0; end else penable = 1;
            wack = (w && n == d) || (stray && !w);
            rack = (!w && n == d) || (stray && w);
            raddrerr = (n == d) ? aerr : 1'($urandom());
            waddrerr = (n == d) ? aerr : 1'($urandom());
            rdata = (n == d) ? rd : $urandom();
        end
    endtask

    task automatic idle(input int k);
        psel = 0; penable = 0; rack = 0; wack = 0;
        repeat (k) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if ({prdata, pready, pslverr, addr, wdata, wstrb, wr_en, rd_en, proto_err} !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {prdata, pready, pslverr, addr, wdata, wstrb, wr_en, rd_en, proto_err}); end
        rst = 1;
        idle(2);
    endtask

    task automatic test_write_zero_wait;
        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, $urandom(), 0, -1);
        total++; if (o_nstb !== 1 || o_stb_n !== 0 || o_wr !== 1) begin bad++; $display("FAIL wr0_strobe got n=%0d at=%0d wr=%b want 1/0/1", o_nstb, o_stb_n, o_wr); end
        total++; if ({o_addr, o_wdata, o_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL wr0_bus got=%h/%h/%h", o_addr, o_wdata, o_wstrb); end
        total++; if (o_rdy_n !== 1 || o_err !== 0 || o_prdata !== 0) begin bad++; $display("FAIL wr0_resp got rdy=%0d err=%b data=%h want 1/0/0", o_rdy_n, o_err, o_prdata); end
        total++; if (o_rdy_after !== 0 || o_both !== 0) begin bad++; $display("FAIL wr0_single got after=%b both=%b want 0/0", o_rdy_after, o_both); end
        idle(1);
    endtask

    task automatic test_read_wait;
        xfer(0, 32'h24, $urandom(), 4'hF, 3, 0, 32'h12345678, 0, -1);
        total++; if (o_nstb !== 1 || o_wr !== 0 || o_addr !== 32'h24 || o_wstrb !== 0) begin bad++; $display("FAIL rd_strobe got n=%0d wr=%b addr=%h strb=%h", o_nstb, o_wr, o_addr, o_wstrb); end
        total++; if (o_rdy_n !== 4 || o_err !== 0 || o_prdata !== 32'h12345678) begin bad++; $display("FAIL rd_resp got rdy=%0d err=%b data=%h want 4/0/12345678", o_rdy_n, o_err, o_prdata); end
        total++; if (o_after !== 0) begin bad++; $display("FAIL rd_data_clear got=%h want 0", o_after); end
        idle(1);
    endtask

    task automatic test_timeout;
        xfer(0, 32'h30, 0, 4'h0, -1, 0, 0, 0, -1);
        total++; if (o_rdy_n !== TO || o_err !== 1 || o_prdata !== 0 || o_nrdy !== 1) begin bad++; $display("FAIL to_none got rdy=%0d err=%b data=%h cnt=%0d", o_rdy_n, o_err, o_prdata, o_nrdy); end
        idle(1);
        xfer(0, 32'h34, 0, 4'h0, TO - 1, 0, 32'hA5A5_0001, 0, -1);
        total++; if (o_rdy_n !== TO || o_err !== 0 || o_prdata !== 32'hA5A5_0001) begin bad++; $display("FAIL to_ack_wins got rdy=%0d err=%b data=%h", o_rdy_n, o_err, o_prdata); end
        idle(0);
        xfer(0, 32'h38, 0, 4'h0, TO, 0, 32'hBEEF_0002, 0, -1);
        total++; if (o_rdy_n !== TO || o_err !== 1 || o_prdata !== 0) begin bad++; $display("FAIL to_late_ack got rdy=%0d err=%b data=%h", o_rdy_n, o_err, o_prdata); end
        idle(2);
    endtask

    task automatic test_addr_err_strobe;
        xfer(1, 32'h40, 32'h0BADF00D, 4'h3, 1, 1, $urandom(), 1, -1);
        total++; if (o_wstrb !== 4'h3 || o_wr !== 1 || o_nstb !== 1) begin bad++; $display("FAIL aerr_strb got strb=%h wr=%b n=%0d", o_wstrb, o_wr, o_nstb); end
        total++; if (o_rdy_n !== 2 || o_err !== 1 || o_prdata !== 0) begin bad++; $display("FAIL aerr_resp got rdy=%0d err=%b data=%h want 2/1/0", o_rdy_n, o_err, o_prdata); end
        idle(1);
        xfer(1, 32'h44, 32'h1, 4'h0, 2, 0, $urandom(), 0, -1);
        total++; if (o_nstb !== 1 || o_wstrb !== 0 || o_rdy_n !== 3 || o_err !== 0) begin bad++; $display("FAIL zero_strb got n=%0d strb=%h rdy=%0d err=%b", o_nstb, o_wstrb, o_rdy_n, o_err); end
        idle(1);
    endtask

    task automatic test_abort;
        xfer(1, 32'h50, 32'h55, 4'hF, 2, 0, 0, 0, 1);
        total++; if (o_nrdy !== 0) begin bad++; $display("FAIL abort_ready got=%0d want 0", o_nrdy); end
        total++; if (o_nperr !== 1 || o_perr_n !== 2) begin bad++; $display("FAIL abort_perr got cnt=%0d at=%0d want 1/2", o_nperr, o_perr_n); end
        idle(1);
        xfer(1, 32'h54, 32'h66, 4'hF, 0, 0, 0, 0, -1);
        total++; if (o_rdy_n !== 1 || o_err !== 0 || o_nperr !== 0 || o_addr !== 32'h54) begin bad++; $display("FAIL abort_recover got rdy=%0d err=%b perr=%0d addr=%h", o_rdy_n, o_err, o_nperr, o_addr); end
        idle(1);
    endtask

    task automatic test_no_setup;
        psel = 1; penable = 1; pwrite = 1;
        @(negedge clk);
        total++; if (proto_err !== 1 || wr_en !== 0 || rd_en !== 0) begin bad++; $display("FAIL nosetup_pulse got perr=%b wr=%b rd=%b want 1/0/0", proto_err, wr_en, rd_en); end
        psel = 0; penable = 0;
        @(negedge clk);
        total++; if (proto_err !== 0 || wr_en !== 0 || rd_en !== 0 || pready !== 0) begin bad++; $display("FAIL nosetup_after got perr=%b wr=%b rd=%b rdy=%b", proto_err, wr_en, rd_en, pready); end
        idle(1);
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'hA5A0; pwdata = 32'hCAFEF00D; pstrb = 4'hC; rack = 0; wack = 0;
        @(negedge clk);
        penable = 1;
        @(negedge clk);
        total++; if (addr !== 32'hA5A0 || wstrb !== 4'hC || pready !== 0) begin bad++; $display("FAIL rstw_hold got addr=%h strb=%h rdy=%b", addr, wstrb, pready); end
        #2 rst = 0;
        #1;
        total++; if ({prdata, pready, pslverr, addr, wdata, wstrb, wr_en, rd_en, proto_err} !== '0) begin bad++; $display("FAIL rstw_async got=%h want 0", {prdata, pready, pslverr, addr, wdata, wstrb, wr_en, rd_en, proto_err}); end
        psel = 0; penable = 0; wack = 1;
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (TO + 2) begin
            @(negedge clk);
            if (pready || wr_en || rd_en || proto_err) seen++;
        end
        wack = 0;
        total++; if (seen !== 0) begin bad++; $display("FAIL rstw_quiet got=%0d want 0", seen); end
    endtask

    task automatic test_back_to_back;
        xfer(1, 32'h60, 32'h0000_1234, 4'h5, 0, 0, 0, 0, -1);
        total++; if (o_nstb !== 1 || o_wr !== 1 || o_rdy_n !== 1 || o_wstrb !== 4'h5) begin bad++; $display("FAIL b2b_wr got n=%0d wr=%b rdy=%0d strb=%h", o_nstb, o_wr, o_rdy_n, o_wstrb); end
        xfer(0, 32'h64, 0, 4'hF, 1, 0, 32'h0000_5678, 0, -1);
        total++; if (o_nstb !== 1 || o_wr !== 0 || o_stb_n !== 0 || o_addr !== 32'h64) begin bad++; $display("FAIL b2b_rd_strobe got n=%0d wr=%b at=%0d addr=%h", o_nstb, o_wr, o_stb_n, o_addr); end
        total++; if (o_rdy_n !== 2 || o_prdata !== 32'h0000_5678 || o_nrdy !== 1) begin bad++; $display("FAIL b2b_rd_resp got rdy=%0d data=%h cnt=%0d", o_rdy_n, o_prdata, o_nrdy); end
        idle(1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic w, aerr, stray;
            logic [31:0] a, wd, rd;
            logic [3:0] st;
            int d;
            w = 1'($urandom()); aerr = ($urandom_range(0, 3) == 0); stray = 1'($urandom());
            a = $urandom(); wd = $urandom(); rd = $urandom(); st = 4'($urandom());
            d = $urandom_range(0, TO + 1);
            if (d == TO + 1) d = -1;
            xfer(w, a, wd, st, d, aerr, rd, stray, -1);
            total++; if (o_nstb !== 1 || o_stb_n !== 0 || o_wr !== w || o_both !== 0) begin bad++; $display("FAIL rnd%0d_strobe got n=%0d at=%0d wr=%b both=%b want wr=%b", i, o_nstb, o_stb_n, o_wr, o_both, w); end
            total++; if (o_addr !== a || o_wstrb !== (w ? st : 4'h0)) begin bad++; $display("FAIL rnd%0d_bus got addr=%h strb=%h want %h/%h", i, o_addr, o_wstrb, a, w ? st : 4'h0); end
            if (w) begin
                total++; if (o_wdata !== wd) begin bad++; $display("FAIL rnd%0d_wdata got=%h want=%h", i, o_wdata, wd); end
            end
            total++; if (o_rdy_n !== exp_rdy(d) || o_err !== exp_err(d, aerr)) begin bad++; $display("FAIL rnd%0d_resp got rdy=%0d err=%b want %0d/%b", i, o_rdy_n, o_err, exp_rdy(d), exp_err(d, aerr)); end
            total++; if (o_prdata !== exp_data(w, d, aerr, rd) || o_after !== 0 || o_rdy_after !== 0) begin bad++; $display("FAIL rnd%0d_data got=%h after=%h want=%h", i, o_prdata, o_after, exp_data(w, d, aerr, rd)); end
            total++; if (o_nperr !== 0) begin bad++; $display("FAIL rnd%0d_perr got=%0d want 0", i, o_nperr); end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset;
        test_write_zero_wait;
        test_read_wait;
        test_timeout;
        test_addr_err_strobe;
        test_abort;
        test_no_setup;
        test_reset_mid_wait;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
